// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline adaptor between the I-cache and D-cache.
// One transaction outstanding downstream; request fields are latched at grant.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic              i_pmem_read,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    // state   | meaning
    // IDLE    | no transaction downstream; sample client requests
    // SERVE_I | I-cache read issued, waiting for pmem_resp
    // SERVE_D | D-cache read or write-back issued, waiting for pmem_resp
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-5){1'b1}}, 5'b0};

    state_t state_q, state_d;
    logic   last_grant_q;     // 0: I served last, 1: D served last
    logic   i_pend, d_pend;
    logic   grant_i, grant_d;

    assign i_pend = i_pmem_read;
    assign d_pend = d_pmem_read | d_pmem_write;

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (state_q)
            IDLE: begin
                // D wins when alone, or on contention when I was served last
                if (d_pend && (!i_pend || !last_grant_q)) begin
                    grant_d = 1'b1;
                    state_d = SERVE_D;
                end else if (i_pend) begin
                    grant_i = 1'b1;
                    state_d = SERVE_I;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    i_pmem_resp = 1'b1;
                    state_d     = IDLE;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    d_pmem_resp = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pmem_address <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_wdata   <= '0;
            last_grant_q <= 1'b0;
        end else if (grant_i) begin
            pmem_address <= i_pmem_address & LINE_MASK;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
        end else if (grant_d) begin
            // read+write together is illegal; the write-back takes precedence
            pmem_address <= d_pmem_address & LINE_MASK;
            pmem_read    <= !d_pmem_write;
            pmem_write   <= d_pmem_write;
            if (d_pmem_write) pmem_wdata <= d_pmem_wdata;
        end else if (i_pmem_resp || d_pmem_resp) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            last_grant_q <= d_pmem_resp;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: grant latency, round-robin, latched write data,
// illegal read+write, spurious resp and mid-transaction reset.
module tb_cache_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] i_pmem_address;
    logic              i_pmem_read;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic [ADDR_W-1:0] d_pmem_address;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_5A = {32{8'h5A}};
    localparam logic [LINE_W-1:0] PAT_RD = {8{32'hC0DE_1234}};

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_pmem_address (i_pmem_address),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_address (d_pmem_address),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_address   (pmem_address),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // drive pmem_resp for one cycle and check both client resps during it
    task automatic resp_pulse(input string tag, input logic exp_i, input logic exp_d);
        pmem_resp = 1'b1;
        #1;
        chk({tag, "_i_resp"}, LINE_W'(i_pmem_resp), LINE_W'(exp_i));
        chk({tag, "_d_resp"}, LINE_W'(d_pmem_resp), LINE_W'(exp_d));
    endtask

    initial begin
        reset_n        = 1'b0;
        i_pmem_address = '0;
        i_pmem_read    = 1'b0;
        d_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_wdata   = '0;
        pmem_rdata     = PAT_RD;
        pmem_resp      = 1'b0;

        // reset values
        #23;
        chk("rst_read",  LINE_W'(pmem_read),    '0);
        chk("rst_write", LINE_W'(pmem_write),   '0);
        chk("rst_addr",  LINE_W'(pmem_address), '0);
        chk("rst_wdata", pmem_wdata,            '0);
        chk("rst_iresp", LINE_W'(i_pmem_resp),  '0);
        chk("rst_dresp", LINE_W'(d_pmem_resp),  '0);
        reset_n = 1'b1;
        cyc();

        // I read alone: pmem_read high for 6 cycles, resp in the 6th
        i_pmem_address = 32'h0000_0064;
        i_pmem_read    = 1'b1;
        cyc();
        chk("i1_read_c1", LINE_W'(pmem_read),    LINE_W'(1));
        chk("i1_addr",    LINE_W'(pmem_address), LINE_W'(32'h0000_0060));
        chk("i1_write",   LINE_W'(pmem_write),   '0);
        for (int k = 2; k <= 6; k++) begin
            cyc();
            chk("i1_read_hold", LINE_W'(pmem_read),   LINE_W'(1));
            chk("i1_no_resp",   LINE_W'(i_pmem_resp), '0);
        end
        resp_pulse("i1", 1'b1, 1'b0);
        chk("i1_irdata", i_pmem_rdata, PAT_RD);
        chk("i1_drdata", d_pmem_rdata, PAT_RD);
        cyc();
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        #1;
        chk("i1_read_drop", LINE_W'(pmem_read),   '0);
        chk("i1_resp_drop", LINE_W'(i_pmem_resp), '0);

        // contention after I was served: D first, then I after one idle cycle
        cyc();
        i_pmem_address = 32'h0000_0100;
        i_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_0213;
        d_pmem_read    = 1'b1;
        cyc();
        chk("rr1_d_read", LINE_W'(pmem_read),    LINE_W'(1));
        chk("rr1_d_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_0200));
        cyc();
        resp_pulse("rr1_d", 1'b0, 1'b1);
        cyc();
        pmem_resp   = 1'b0;
        d_pmem_read = 1'b0;
        #1;
        chk("rr1_idle_gap", LINE_W'(pmem_read), '0);
        cyc();
        chk("rr1_i_read", LINE_W'(pmem_read),    LINE_W'(1));
        chk("rr1_i_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_0100));
        resp_pulse("rr1_i", 1'b1, 1'b0);
        cyc();
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;

        // D write-back; client data/address change after grant must not leak
        cyc();
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata   = PAT_A5;
        d_pmem_write   = 1'b1;
        cyc();
        chk("dw_write", LINE_W'(pmem_write),   LINE_W'(1));
        chk("dw_read",  LINE_W'(pmem_read),    '0);
        chk("dw_addr",  LINE_W'(pmem_address), LINE_W'(32'h0000_1000));
        chk("dw_wdata", pmem_wdata,            PAT_A5);
        d_pmem_wdata   = PAT_5A;
        d_pmem_address = 32'h0000_FFFF;
        cyc();
        cyc();
        chk("dw_wdata_hold", pmem_wdata,            PAT_A5);
        chk("dw_addr_hold",  LINE_W'(pmem_address), LINE_W'(32'h0000_1000));
        chk("dw_write_hold", LINE_W'(pmem_write),   LINE_W'(1));
        resp_pulse("dw", 1'b0, 1'b1);
        cyc();
        pmem_resp    = 1'b0;
        d_pmem_write = 1'b0;
        #1;
        chk("dw_write_drop", LINE_W'(pmem_write), '0);

        // contention after D was served: I first
        cyc();
        i_pmem_address = 32'h0000_02A0;
        i_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_0345;
        d_pmem_read    = 1'b1;
        cyc();
        chk("rr2_i_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_02A0));
        chk("rr2_i_read", LINE_W'(pmem_read),    LINE_W'(1));
        resp_pulse("rr2_i", 1'b1, 1'b0);
        cyc();
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        #1;
        chk("rr2_idle_gap", LINE_W'(pmem_read), '0);
        cyc();
        chk("rr2_d_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_0340));
        resp_pulse("rr2_d", 1'b0, 1'b1);
        cyc();
        pmem_resp   = 1'b0;
        d_pmem_read = 1'b0;

        // illegal D read+write: write only
        cyc();
        d_pmem_address = 32'h0000_0400;
        d_pmem_wdata   = PAT_5A;
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        cyc();
        chk("rw_write", LINE_W'(pmem_write), LINE_W'(1));
        chk("rw_read",  LINE_W'(pmem_read),  '0);
        chk("rw_wdata", pmem_wdata,          PAT_5A);
        resp_pulse("rw", 1'b0, 1'b1);
        cyc();
        pmem_resp    = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;

        // spurious resp in IDLE
        cyc();
        resp_pulse("spur", 1'b0, 1'b0);
        cyc();
        pmem_resp = 1'b0;
        #1;
        chk("spur_read",  LINE_W'(pmem_read),  '0);
        chk("spur_write", LINE_W'(pmem_write), '0);
        i_pmem_address = 32'h0000_0520;
        i_pmem_read    = 1'b1;
        cyc();
        chk("spur_then_grant", LINE_W'(pmem_read), LINE_W'(1));
        resp_pulse("spur_follow", 1'b1, 1'b0);
        cyc();
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;

        // reset mid SERVE_I, late resp must be dropped
        cyc();
        i_pmem_address = 32'h0000_0080;
        i_pmem_read    = 1'b1;
        cyc();
        chk("rstmid_read_pre", LINE_W'(pmem_read), LINE_W'(1));
        cyc();
        reset_n = 1'b0;
        #1;
        chk("rstmid_read_async", LINE_W'(pmem_read),    '0);
        chk("rstmid_addr_async", LINE_W'(pmem_address), '0);
        i_pmem_read = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        resp_pulse("rstmid_late", 1'b0, 1'b0);
        chk("rstmid_read_post", LINE_W'(pmem_read), '0);
        cyc();
        pmem_resp = 1'b0;
        d_pmem_address = 32'h0000_0600;
        d_pmem_read    = 1'b1;
        cyc();
        chk("rstmid_idle_grant", LINE_W'(pmem_read),    LINE_W'(1));
        chk("rstmid_idle_addr",  LINE_W'(pmem_address), LINE_W'(32'h0000_0600));
        resp_pulse("rstmid_follow", 1'b0, 1'b1);
        cyc();
        pmem_resp   = 1'b0;
        d_pmem_read = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 The block SHALL have parameter LINE_W, default 256, cacheline width in bits.
REQ-003 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 i_pmem_address  input  ADDR_W  I-cache line miss address.
REQ-007 i_pmem_read  input  1  I-cache line read request.
REQ-008 i_pmem_rdata  output  LINE_W  line returned to I-cache.
REQ-009 i_pmem_resp  output  1  I-cache transaction complete.
REQ-010 d_pmem_address  input  ADDR_W  D-cache line address.
REQ-011 d_pmem_read  input  1  D-cache line read request.
REQ-012 d_pmem_write  input  1  D-cache line write-back request.
REQ-013 d_pmem_wdata  input  LINE_W  D-cache write-back line.
REQ-014 d_pmem_rdata  output  LINE_W  line returned to D-cache.
REQ-015 d_pmem_resp  output  1  D-cache transaction complete.
REQ-016 pmem_address  output  ADDR_W  line address to cacheline adaptor.
REQ-017 pmem_read  output  1  line read to cacheline adaptor.
REQ-018 pmem_write  output  1  line write to cacheline adaptor.
REQ-019 pmem_wdata  output  LINE_W  write line to cacheline adaptor.
REQ-020 pmem_rdata  input  LINE_W  line from cacheline adaptor.
REQ-021 pmem_resp  input  1  adaptor transaction complete.

Function
REQ-022 FSM states SHALL be IDLE, SERVE_I, SERVE_D; one transaction outstanding downstream at a time.
REQ-023 IDLE: only I pending -> SERVE_I; only D pending (read or write) -> SERVE_D; none -> stay IDLE.
REQ-024 Both pending in IDLE: grant client not served last (round-robin via registered last_grant bit).
REQ-025 On grant edge: register address with bits [4:0] forced to 0, operation type, and (for D write) d_pmem_wdata.
REQ-026 pmem_read/pmem_write SHALL be registered, assert the cycle after the request is seen in IDLE (1-cycle grant latency), and hold steady until pmem_resp.
REQ-027 pmem_address and pmem_wdata SHALL hold registered values for the whole transaction regardless of client input changes.
REQ-028 D with read and write both high is illegal; arbiter SHALL issue the write only.
REQ-029 In SERVE_x, the cycle pmem_resp=1: x_pmem_resp=1 combinationally that same cycle; pmem_read/pmem_write drop at that edge; last_grant<=x; state<=IDLE.
REQ-030 The non-granted client's resp SHALL stay 0 throughout; x_pmem_resp never asserts outside the resp_i cycle.
REQ-031 i_pmem_rdata and d_pmem_rdata SHALL both equal pmem_rdata combinationally; validity is indicated only by the respective resp.
REQ-032 Clients SHALL deassert a request the cycle after resp; the IDLE cycle after completion SHALL re-sample requests, so back-to-back transactions incur 1 idle cycle.
REQ-033 pmem_resp in IDLE SHALL be ignored (no client resp, no state change).
REQ-034 A request withdrawn before grant SHALL not be issued; a request withdrawn after grant SHALL still complete downstream.

Reset
REQ-035 While reset_n=0: state=IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, last_grant=I (first contention goes to D), i/d_pmem_resp=0.
REQ-036 Reset asserted mid-transaction SHALL abort it immediately (async), drop pmem_read/pmem_write the same instant, and not forward any later pmem_resp.

Verification
REQ-037 I read 0x0000_0064 alone, adaptor resp after 5 cycles -> pmem_read high cycles 1..6, pmem_address=0x0000_0060, i_pmem_resp pulses 1 cycle, d_pmem_resp stays 0.
REQ-038 I read and D read simultaneous after reset -> D served first, then I after one IDLE cycle; repeat both -> I first (round-robin).
REQ-039 D write 0x0000_1000, wdata=0xA5..A5, client changes wdata after grant -> pmem_write high, pmem_wdata stays 0xA5..A5 until resp.
REQ-040 D asserts read and write together -> only pmem_write asserted, pmem_read stays 0.
REQ-041 reset_n pulled low mid SERVE_I, pmem_resp arrives after release -> no i_pmem_resp, pmem_read=0, FSM in IDLE.
REQ-042 Spurious pmem_resp in IDLE -> no client resp, no state change.
